ysyx_22040632_mem_responder: RTL
================================

# ysyx_22040632_mem_responder

Memory-side responder for the NPC core's data/instruction memory port. It replaces the DPI `paddr_read` path with synthesizable RTL. The block accepts one read or write request at a time over a valid/ready channel and serves it from an internal 64-bit-wide word array after a fixed, programmable latency. It returns the result over a valid/ready response channel. It sits between the core's LSU/IFU arbiter and the memory array, and flags out-of-range accesses instead of exiting the simulation.

## Interface
- `DEPTH`, default 4096: number of 64-bit words in the array; power of two.
- `BASE_ADDR`, default 64'h8000_0000: physical address of word 0.
- `LATENCY`, default 2: cycles from request acceptance to first `rsp_valid`; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_addr` in 64: byte address; bits [2:0] are ignored, so every access is doubleword-aligned.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_wdata` in 64: write data.
- `req_wmask` in 8: byte-lane write enables; bit i enables byte i.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out 64: read data; 0 for writes and errors.
- `rsp_err` out 1: the access fell outside [BASE_ADDR, BASE_ADDR+DEPTH*8).

## Operation
- FSM states are IDLE, WAIT and RESP. Reset state is IDLE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch addr, wen, wdata and wmask.
  - Compute `in_range` = (addr >= BASE_ADDR) && (addr - BASE_ADDR < DEPTH*8), using 64-bit unsigned arithmetic. Addresses below BASE_ADDR do not wrap.
  - Load the countdown with LATENCY-1.
  - Go to RESP if LATENCY==1, else go to WAIT.
- **WAIT:**
  - `req_ready`=0.
  - Decrement the counter each cycle.
  - Go to RESP on the edge where the counter is 1.
- **Action on the edge entering RESP:**
  - Index = (addr - BASE_ADDR)[log2(DEPTH)+2:3].
  - Write in range: every byte lane with mask=1 is updated; lanes with mask=0 keep their old value. `rsp_rdata` is set to 0.
  - Read in range: `rsp_rdata` is set to the array word, which reflects all earlier committed writes.
  - Out of range: no array update, `rsp_rdata`=0, `rsp_err`=1.
- **RESP:**
  - `rsp_valid`=1.
  - `rsp_rdata` and `rsp_err` are held stable until `rsp_valid`&&`rsp_ready`, then the FSM returns to IDLE.
  - `req_ready`=0 throughout RESP, so requests are never overlapped or pipelined.
- A write with wmask=0 is legal. It commits nothing and returns a normal response with `rsp_err`=0.
- The array contents are not reset. Only control state and outputs are reset.

## Timing
- Reset values:
  - `req_ready`=1, which is asserted combinationally from IDLE.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - Counter=0.
- Latency: if the request is accepted at edge T, `rsp_valid` is first high in the cycle after edge T+LATENCY-1. With LATENCY=1, `rsp_valid` is high in the cycle immediately after acceptance.
- Throughput: one request per LATENCY+1 cycles at best, when `rsp_ready` is held high. After the response handshake at edge R, `req_ready`=1 in the cycle after R.
- Back-pressure: `rsp_ready`=0 stalls in RESP indefinitely with outputs unchanged. A new `req_valid` is ignored while stalled.
- `req_*` inputs are sampled only at acceptance; later changes have no effect.
- Asynchronous reset mid-operation:
  - The FSM returns to IDLE immediately and outputs take their reset values.
  - A write is committed only on the edge entering RESP. If reset asserts during WAIT, the write is dropped.
  - A write already committed stays in the array.
- Read-after-write to the same address returns the new data when issued as the next request.

## Test plan
- **Reset:** assert `rst` asynchronously between clock edges -> `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0 without waiting for a clock edge.
- **Basic write/read, LATENCY=2:**
  - Write addr 0x8000_0010, data 0x1122_3344_5566_7788, mask 0xFF -> `rsp_valid` high 2 cycles after acceptance, `rsp_err`=0.
  - Then read 0x8000_0017 -> `rsp_rdata`=0x1122_3344_5566_7788.
- **Partial mask:**
  - Word holds 0xFFFF_FFFF_FFFF_FFFF.
  - Write data 0, mask 0x0F -> a later read returns 0xFFFF_FFFF_0000_0000.
- **Out of range:**
  - Read 0x7FFF_FFF8 -> `rsp_err`=1, `rsp_rdata`=0.
  - Write BASE+DEPTH*8 -> `rsp_err`=1, and the array is unchanged (check the last word before and after).
- **Back-pressure:**
  - Hold `rsp_ready`=0 for 5 cycles and drive a second `req_valid` -> `rsp_valid` and data stay stable, `req_ready`=0, and the second request is accepted only in the cycle after the handshake.
- **Reset mid-WAIT, LATENCY=4:**
  - Write 0xDEAD to word 0, assert `rst` in the 2nd WAIT cycle, release it, then read word 0 -> the read returns the previous contents, not 0xDEAD.

Source files
------------

// File: rtl/ysyx_22040632_mem_responder_if.sv
// rtl/ysyx_22040632_mem_responder_if.sv - request/response channel between the core arbiter and the memory responder
interface ysyx_22040632_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22040632_mem_responder.sv
// rtl/ysyx_22040632_mem_responder.sv - fixed-latency single-outstanding memory responder over a 64-bit word array
module ysyx_22040632_mem_responder #(
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic clk,
    input  logic rst,
    ysyx_22040632_mem_responder_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt;
    logic [AW-1:0]   idx_q;
    logic            wen_q;
    logic [63:0]     wdata_q;
    logic [7:0]      wmask_q;
    logic            in_range_q;
    logic [63:0]     rdata_q;
    logic            err_q;
    logic [63:0]     mem [DEPTH];

    logic            accept, enter_resp, handshake;
    logic [63:0]     req_base, req_off;
    logic            req_in_range;
    logic [AW-1:0]   c_idx;
    logic            c_wen, c_in_range;
    logic [63:0]     c_wdata;
    logic [7:0]      c_wmask;

    assign req_base     = bus.req_addr & ~64'h7;
    assign req_off      = req_base - BASE_ADDR;
    assign req_in_range = (req_base >= BASE_ADDR) && (req_off < SPAN);

    // With LATENCY==1 the commit happens on the accept edge, before the latches are loaded
    assign c_idx      = (state == IDLE) ? req_off[AW+2:3] : idx_q;
    assign c_wen      = (state == IDLE) ? bus.req_wen     : wen_q;
    assign c_wdata    = (state == IDLE) ? bus.req_wdata   : wdata_q;
    assign c_wmask    = (state == IDLE) ? bus.req_wmask   : wmask_q;
    assign c_in_range = (state == IDLE) ? req_in_range    : in_range_q;

    always_comb begin
        state_n       = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        accept        = 1'b0;
        enter_resp    = 1'b0;
        handshake     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_n    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    handshake = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            idx_q      <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
            in_range_q <= 1'b0;
            rdata_q    <= 64'd0;
            err_q      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt        <= 4'(LATENCY - 1);
                idx_q      <= req_off[AW+2:3];
                wen_q      <= bus.req_wen;
                wdata_q    <= bus.req_wdata;
                wmask_q    <= bus.req_wmask;
                in_range_q <= req_in_range;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rdata_q <= (c_in_range && !c_wen) ? mem[c_idx] : 64'd0;
                err_q   <= !c_in_range;
            end else if (handshake) begin
                rdata_q <= 64'd0;
                err_q   <= 1'b0;
            end
        end
    end

    // Array is deliberately not reset; only the edge entering RESP commits a write
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && c_in_range && c_wen) begin
            for (int i = 0; i < 8; i++) begin
                if (c_wmask[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
